// File: rtl/arb_pkg.sv
// arb_pkg: shared types and default constants for the arbitrated bus requester
package arb_pkg;
   localparam int ADDR_W             = 8;
   localparam int HOLD_CYCLES_DEF    = 2;
   localparam int TIMEOUT_CYCLES_DEF = 15;
   typedef enum logic [1:0] {IDLE, REQUEST, DRIVE, RELEASE} state_e;
endpackage

// File: rtl/bus_tristate_drv.sv
// bus_tristate_drv: drives the shared address bus only while enabled, high-Z otherwise
module bus_tristate_drv
   import arb_pkg::*;
(
   input  logic              en,
   input  logic [ADDR_W-1:0] data,
   inout  wire  [ADDR_W-1:0] bus
);
   assign bus = en ? data : {ADDR_W{1'bz}};
endmodule

// File: rtl/arb_requester.sv
// arb_requester: requests a shared bus, drives an address for HOLD_CYCLES per grant;
// macro ARB_REQUESTER_TIMEOUT_EN adds a grant-wait timeout that ends in an err pulse
module arb_requester
   import arb_pkg::*;
#(
   parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              cmd_ready,
   output logic              req,
   input  logic              gnt,
   inout  wire  [ADDR_W-1:0] address,
   output logic              done,
   output logic              err
);
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("HOLD_CYCLES must be 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be 1..255");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        hold_q, hold_d;
   logic              abort_q, abort_d;
   logic              drv_en;

`ifdef ARB_REQUESTER_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
   logic       timeout;
   // wait counter runs only while requesting and restarts on every new request
   always_comb begin
      wait_d  = state_q == REQUEST ? wait_q + 8'd1 : 8'd0;
      timeout = state_q == REQUEST && wait_q == 8'(TIMEOUT_CYCLES - 1);
   end
   // wait counter register
   always_ff @(posedge clock) begin
      if (reset) wait_q <= '0;
      else       wait_q <= wait_d;
   end
`else
   logic timeout;
   assign timeout = 1'b0;
`endif

   // next-state logic; a grant seen outside REQUEST/DRIVE has no effect
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      abort_d = abort_q;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               state_d = REQUEST;
            end
         end
         REQUEST: begin
            if (gnt) begin
               state_d = DRIVE;
               hold_d  = 4'(HOLD_CYCLES - 1);
            end else if (timeout) begin
               state_d = RELEASE;
               abort_d = 1'b1;
            end
         end
         DRIVE: begin
            if (!gnt) begin
               state_d = RELEASE;
               abort_d = 1'b1;
            end else if (hold_q == 4'd0) begin
               state_d = RELEASE;
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs decode from registered state; bus enable is gated by the live grant
   always_comb begin
      cmd_ready = state_q == IDLE;
      req       = state_q == REQUEST || state_q == DRIVE;
      done      = state_q == RELEASE && !abort_q;
      err       = state_q == RELEASE && abort_q;
      drv_en    = state_q == DRIVE && gnt;
   end

   // state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         hold_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
         abort_q <= abort_d;
      end
   end

   bus_tristate_drv u_drv (
      .en   (drv_en),
      .data (addr_q),
      .bus  (address)
   );
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed bench for arb_requester (two instances: HOLD 2/TO 15, HOLD 3/TO 4)
module tb_arb_requester;
   logic clk = 0, rst = 1;
   logic cv_a = 0, gnt_a = 0, rdy_a, req_a, done_a, err_a;
   logic cv_b = 0, gnt_b = 0, rdy_b, req_b, done_b, err_b;
   logic [7:0] ca_a = 0, ca_b = 0;
   wire  [7:0] bus_a, bus_b;
   int checks = 0, errors = 0;
   localparam logic [7:0] ZV = 8'hFF;

   pullup (bus_a);
   pullup (bus_b);

   always #5 clk = ~clk;

   arb_requester #(.HOLD_CYCLES(2), .TIMEOUT_CYCLES(15)) u_a (
      .clock(clk), .reset(rst), .cmd_valid(cv_a), .cmd_addr(ca_a), .cmd_ready(rdy_a),
      .req(req_a), .gnt(gnt_a), .address(bus_a), .done(done_a), .err(err_a));

   arb_requester #(.HOLD_CYCLES(3), .TIMEOUT_CYCLES(4)) u_b (
      .clock(clk), .reset(rst), .cmd_valid(cv_b), .cmd_addr(ca_b), .cmd_ready(rdy_b),
      .req(req_b), .gnt(gnt_b), .address(bus_b), .done(done_b), .err(err_b));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1;
      tick; tick; #1;
      checks++; if ({rdy_a, req_a, done_a, err_a} !== 4'b1000) begin errors++; $display("FAIL reset_a flags got %b exp 1000", {rdy_a, req_a, done_a, err_a}); end
      checks++; if (bus_a !== ZV) begin errors++; $display("FAIL reset_a bus got %h exp %h", bus_a, ZV); end
      checks++; if ({rdy_b, req_b, done_b, err_b} !== 4'b1000) begin errors++; $display("FAIL reset_b flags got %b exp 1000", {rdy_b, req_b, done_b, err_b}); end
      checks++; if (bus_b !== ZV) begin errors++; $display("FAIL reset_b bus got %h exp %h", bus_b, ZV); end
      rst = 0;
   endtask

   task automatic test_basic;
      tick; cv_a = 1; ca_a = 8'hA5; gnt_a = 1; #1;
      checks++; if ({rdy_a, req_a} !== 2'b10) begin errors++; $display("FAIL basic_n rdy/req got %b exp 10", {rdy_a, req_a}); end
      tick; cv_a = 0; #1;
      checks++; if ({req_a, bus_a} !== {1'b1, ZV}) begin errors++; $display("FAIL basic_n1 req/bus got %b/%h exp 1/%h", req_a, bus_a, ZV); end
      tick; #1;
      checks++; if ({req_a, bus_a} !== 9'h1A5) begin errors++; $display("FAIL basic_n2 req/bus got %b/%h exp 1/a5", req_a, bus_a); end
      tick; #1;
      checks++; if (bus_a !== 8'hA5) begin errors++; $display("FAIL basic_n3 bus got %h exp a5", bus_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_n3 done got %b exp 0", done_a); end
      tick; #1;
      checks++; if ({rdy_a, req_a, done_a, err_a} !== 4'b0010) begin errors++; $display("FAIL basic_n4 flags got %b exp 0010", {rdy_a, req_a, done_a, err_a}); end
      checks++; if (bus_a !== ZV) begin errors++; $display("FAIL basic_n4 bus got %h exp %h", bus_a, ZV); end
      tick; gnt_a = 0; #1;
      checks++; if ({rdy_a, req_a, done_a, err_a} !== 4'b1000) begin errors++; $display("FAIL basic_n5 flags got %b exp 1000", {rdy_a, req_a, done_a, err_a}); end
   endtask

   task automatic test_delayed_gnt;
      int reqs = 0, zbad = 0, dones = 0;
      tick; cv_a = 1; ca_a = 8'h5A; gnt_a = 0; #1;
      tick; cv_a = 0;
      for (int i = 0; i < 6; i++) begin
         gnt_a = (i == 5); #1;
         if (req_a === 1'b1) reqs++;
         if (bus_a !== ZV) zbad++;
         tick;
      end
      checks++; if (reqs !== 6) begin errors++; $display("FAIL delayed req_cycles got %0d exp 6", reqs); end
      checks++; if (zbad !== 0) begin errors++; $display("FAIL delayed bus_z_while_waiting got %0d bad exp 0", zbad); end
      #1;
      checks++; if (bus_a !== 8'h5A) begin errors++; $display("FAIL delayed drive1 bus got %h exp 5a", bus_a); end
      tick; #1;
      checks++; if (bus_a !== 8'h5A) begin errors++; $display("FAIL delayed drive2 bus got %h exp 5a", bus_a); end
      for (int i = 0; i < 4; i++) begin
         tick; gnt_a = 0; #1;
         if (done_a === 1'b1) dones++;
         checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL delayed err got %b exp 0", err_a); end
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL delayed done_pulses got %0d exp 1", dones); end
   endtask

   task automatic test_timeout;
      int reqs = 0, errs = 0;
      tick; cv_b = 1; ca_b = 8'h99; gnt_b = 0; #1;
      tick; cv_b = 0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         #1; if (req_b === 1'b1) reqs++;
         tick;
      end
      checks++; if (reqs !== 4) begin errors++; $display("FAIL timeout req_cycles got %0d exp 4", reqs); end
      #1;
      checks++; if ({req_b, err_b, done_b} !== 3'b010) begin errors++; $display("FAIL timeout release req/err/done got %b exp 010", {req_b, err_b, done_b}); end
      for (int i = 0; i < 4; i++) begin
         if (err_b === 1'b1) errs++;
         tick; #1;
      end
      checks++; if (errs !== 1) begin errors++; $display("FAIL timeout err_pulses got %0d exp 1", errs); end
      checks++; if ({rdy_b, req_b} !== 2'b10) begin errors++; $display("FAIL timeout idle rdy/req got %b exp 10", {rdy_b, req_b}); end
`else
      for (int i = 0; i < 100; i++) begin
         #1; if (req_b === 1'b1) reqs++;
         if (err_b === 1'b1) errs++;
         tick;
      end
      checks++; if (reqs !== 100) begin errors++; $display("FAIL wait_forever req_cycles got %0d exp 100", reqs); end
      checks++; if (errs !== 0) begin errors++; $display("FAIL wait_forever err_pulses got %0d exp 0", errs); end
      rst = 1; tick; rst = 0;
`endif
   endtask

   task automatic test_lost_gnt;
      int dones = 0, errs = 0;
      tick; cv_b = 1; ca_b = 8'h77; gnt_b = 1; #1;
      tick; cv_b = 0; #1;
      tick; gnt_b = 0; #1;
      checks++; if ({req_b, bus_b} !== {1'b1, ZV}) begin errors++; $display("FAIL lost_gnt drive req/bus got %b/%h exp 1/%h", req_b, bus_b, ZV); end
      for (int i = 0; i < 4; i++) begin
         tick; #1;
         if (done_b === 1'b1) dones++;
         if (err_b === 1'b1) errs++;
      end
      checks++; if (errs !== 1) begin errors++; $display("FAIL lost_gnt err_pulses got %0d exp 1", errs); end
      checks++; if (dones !== 0) begin errors++; $display("FAIL lost_gnt done_pulses got %0d exp 0", dones); end
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      tick; cv_a = 1; ca_a = 8'h3C; gnt_a = 1; #1;
      tick; cv_a = 0; #1;
      tick; #1;
      checks++; if (bus_a !== 8'h3C) begin errors++; $display("FAIL reset_mid drive bus got %h exp 3c", bus_a); end
      rst = 1;
      tick; rst = 0; #1;
      checks++; if ({rdy_a, req_a, done_a, err_a} !== 4'b1000) begin errors++; $display("FAIL reset_mid flags got %b exp 1000", {rdy_a, req_a, done_a, err_a}); end
      checks++; if (bus_a !== ZV) begin errors++; $display("FAIL reset_mid bus got %h exp %h", bus_a, ZV); end
      for (int i = 0; i < 4; i++) begin
         tick; #1;
         if (done_a === 1'b1 || err_a === 1'b1) pulses++;
      end
      gnt_a = 0;
      checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid pulses got %0d exp 0", pulses); end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      tick; cv_a = 1; ca_a = 8'h22; gnt_a = 1; #1;
      tick; ca_a = 8'h11; #1;
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL b2b busy rdy got %b exp 0", rdy_a); end
      for (int i = 0; i < 2; i++) begin
         tick; #1;
         if (rdy_a !== 1'b0) bad++;
         checks++; if (bus_a !== 8'h22) begin errors++; $display("FAIL b2b drive%0d bus got %h exp 22", i, bus_a); end
      end
      tick; cv_a = 0; #1;
      checks++; if ({rdy_a, done_a, bus_a} !== {2'b01, ZV}) begin errors++; $display("FAIL b2b release rdy/done/bus got %b/%b/%h exp 0/1/%h", rdy_a, done_a, bus_a, ZV); end
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         if (req_a !== 1'b0 || bus_a !== ZV) bad++;
      end
      gnt_a = 0;
      checks++; if (bad !== 0) begin errors++; $display("FAIL b2b second_cmd_leak got %0d bad cycles exp 0", bad); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_delayed_gnt;
      test_timeout;
      test_lost_gnt;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
